// File: rtl/ps2_frame_rx_if.sv
// ps2_frame_rx_if: raw PS/2 line inputs and the decoded key-code strobe bundle
interface ps2_frame_rx_if;
  logic kclk;
  logic kdat;
  logic sc_valid;
  logic [7:0] sc_code;
  logic sc_ext;
  logic sc_rel;
  logic err_par;
  logic err_frm;
  modport master(
    output kclk, kdat,
    input sc_valid, sc_code, sc_ext, sc_rel, err_par, err_frm
  );
  modport slave(
    input kclk, kdat,
    output sc_valid, sc_code, sc_ext, sc_rel, err_par, err_frm
  );
endinterface

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 device-to-host frame receiver with clock glitch filter,
// frame checking and E0/F0 prefix folding into a single key-code strobe.
module ps2_frame_rx #(
  parameter int FILT   = 3,
  parameter int TOUT_W = 12
) (
  input  logic           clk,
  input  logic           rstn,
  ps2_frame_rx_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;
  state_t state, state_n;
  logic [1:0] kclk_s, kdat_s;
  logic [3:0] fcnt;
  logic fclk, fclk_q, fall, kd, tout;
  logic ok, bad_par, bad_stop, par, par_n;
  logic ext, rel;
  logic [2:0] bits, bits_n;
  logic [7:0] shift, shift_n;
  logic [TOUT_W-1:0] tcnt;
  logic sc_valid, sc_ext, sc_rel, err_par, err_frm;
  logic [7:0] sc_code;
  assign fall = fclk_q & ~fclk;
  assign kd   = kdat_s[1];
  assign tout = (&tcnt) & ~fall & (state != IDLE);
  // The filtered clock only follows the synchroniser after FILT consecutive differing samples
  always_ff @(posedge clk) begin
    if (!rstn) begin
      kclk_s <= 2'b11;
      kdat_s <= 2'b11;
      fcnt   <= '0;
      fclk   <= 1'b1;
      fclk_q <= 1'b1;
      tcnt   <= '0;
    end else begin
      kclk_s <= {kclk_s[0], bus.kclk};
      kdat_s <= {kdat_s[0], bus.kdat};
      fcnt   <= (kclk_s[1] == fclk || fcnt == 4'(FILT - 1)) ? '0 : fcnt + 4'd1;
      if (kclk_s[1] != fclk && fcnt == 4'(FILT - 1)) fclk <= kclk_s[1];
      fclk_q <= fclk;
      tcnt   <= fall ? '0 : (&tcnt ? tcnt : tcnt + 1'b1);
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      bits  <= '0;
      shift <= '0;
      par   <= 1'b0;
    end else begin
      state <= state_n;
      bits  <= bits_n;
      shift <= shift_n;
      par   <= par_n;
    end
  end
  always_comb begin
    state_n  = state;
    bits_n   = bits;
    shift_n  = shift;
    par_n    = par;
    ok       = 1'b0;
    bad_par  = 1'b0;
    bad_stop = 1'b0;
    if (tout) state_n = IDLE;
    else if (fall) begin
      case (state)
        IDLE: begin
          state_n = kd ? IDLE : DATA;
          bits_n  = '0;
        end
        DATA: begin
          shift_n = {kd, shift[7:1]};
          bits_n  = bits + 3'd1;
          state_n = (bits == 3'd7) ? PAR : DATA;
        end
        PAR: begin
          par_n   = kd;
          state_n = STOP;
        end
        default: begin
          state_n  = IDLE;
          bad_stop = ~kd;
          bad_par  = kd & ~(^shift ^ par);
          ok       = kd & (^shift ^ par);
        end
      endcase
    end
  end
  // Prefix bytes only update flags; every error drops any pending prefix
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sc_valid <= 1'b0;
      sc_code  <= '0;
      sc_ext   <= 1'b0;
      sc_rel   <= 1'b0;
      err_par  <= 1'b0;
      err_frm  <= 1'b0;
      ext      <= 1'b0;
      rel      <= 1'b0;
    end else begin
      sc_valid <= ok && shift != 8'hE0 && shift != 8'hF0;
      err_par  <= bad_par;
      err_frm  <= bad_stop | tout;
      if (bad_par || bad_stop || tout) begin
        ext <= 1'b0;
        rel <= 1'b0;
      end else if (ok) begin
        if (shift == 8'hE0) ext <= 1'b1;
        else if (shift == 8'hF0) rel <= 1'b1;
        else begin
          sc_code <= shift;
          sc_ext  <= ext;
          sc_rel  <= rel;
          ext     <= 1'b0;
          rel     <= 1'b0;
        end
      end
    end
  end
  assign bus.sc_valid = sc_valid;
  assign bus.sc_code  = sc_code;
  assign bus.sc_ext   = sc_ext;
  assign bus.sc_rel   = sc_rel;
  assign bus.err_par  = err_par;
  assign bus.err_frm  = err_frm;
endmodule
